// File: rtl/cpu7_ifu_dec_ctl.sv
// Issue controller between fetch and decode: 2-entry in-order buffer, GPR hazard scoreboard, flush.
// Optional CPU7_DEC_CTL_PERF_EN adds a saturating hazard-stall cycle counter (perf_stall_cnt).
module cpu7_ifu_dec_ctl #(
    parameter int PC_W        = 32,
    parameter int STALL_CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fdp_valid,
    input  logic [PC_W-1:0] fdp_pc,
    input  logic [31:0]     fdp_inst,
    output logic            fdp_ready,
    output logic            dec_valid,
    output logic [PC_W-1:0] dec_pc,
    output logic [31:0]     dec_inst,
    input  logic            dec_rf_wen,
    input  logic            dec_long_lat,
    input  logic            exu_ready,
    output logic            dec_stall,
    input  logic            wb_valid,
    input  logic [4:0]      wb_addr,
    input  logic            exu_flush,
    output logic [31:0]     sb_busy
`ifdef CPU7_DEC_CTL_PERF_EN
    ,
    output logic [STALL_CNT_W-1:0] perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } cnt_e;

    cnt_e            state_q, state_d;
    logic            rd_ptr, wr_ptr;
    logic [PC_W-1:0] buf_pc   [2];
    logic [31:0]     buf_inst [2];
    logic [31:0]     sb_d, sb_eff, wb_clr, sb_set;
    logic [4:0]      rd, rj, rk;
    logic            push, issue, hazard, present;

    assign fdp_ready = !rst && (state_q != FULL);
    assign push      = fdp_valid && fdp_ready && !exu_flush;
    assign present   = (state_q != EMPTY);

    assign dec_pc   = buf_pc[rd_ptr];
    assign dec_inst = buf_inst[rd_ptr];
    assign rd       = dec_inst[4:0];
    assign rj       = dec_inst[9:5];
    assign rk       = dec_inst[14:10];

    // A writeback landing this cycle already frees its register for the head.
    assign wb_clr = (wb_valid && wb_addr != 5'd0) ? (32'd1 << wb_addr) : '0;
    assign sb_eff = sb_busy & ~wb_clr;

    always_comb begin
        hazard = 1'b0;
        if (rj != 5'd0 && sb_eff[rj])
            hazard = 1'b1;
        if (rk != 5'd0 && sb_eff[rk])
            hazard = 1'b1;
        if (dec_rf_wen && rd != 5'd0 && sb_eff[rd])
            hazard = 1'b1;
    end

    assign dec_valid = present && !hazard && !exu_flush;
    assign dec_stall = present && hazard && !exu_flush;
    assign issue     = dec_valid && exu_ready;

    always_comb begin
        state_d = state_q;
        if (exu_flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (push) state_d = ONE;
                ONE: begin
                    if (push && !issue)
                        state_d = FULL;
                    else if (issue && !push)
                        state_d = EMPTY;
                end
                FULL: if (issue) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (exu_flush) begin
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= ~wr_ptr;
                if (issue)
                    rd_ptr <= ~rd_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]   <= fdp_pc;
            buf_inst[wr_ptr] <= fdp_inst;
        end
    end

    // Set is applied after clear so a same-index issue wins over the writeback.
    assign sb_set = (issue && dec_long_lat && dec_rf_wen && rd != 5'd0) ? (32'd1 << rd) : '0;

    always_comb begin
        sb_d    = (sb_busy & ~wb_clr) | sb_set;
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            sb_busy <= '0;
        else
            sb_busy <= sb_d;
    end

`ifdef CPU7_DEC_CTL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst)
            perf_stall_cnt <= '0;
        else if (dec_stall && perf_stall_cnt != '1)
            perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_cpu7_ifu_dec_ctl.sv
// Directed bench for cpu7_ifu_dec_ctl: reference model of buffer/scoreboard, expected issue queue.
module tb_cpu7_ifu_dec_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fdp_valid = 1'b0;
    logic [31:0] fdp_pc = '0;
    logic [31:0] fdp_inst = '0;
    logic        fdp_ready;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_inst;
    logic        dec_rf_wen;
    logic        dec_long_lat;
    logic        exu_ready = 1'b0;
    logic        dec_stall;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic        exu_flush = 1'b0;
    logic [31:0] sb_busy;
`ifdef CPU7_DEC_CTL_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    // Decoder stand-in: bit31 marks long latency, bit30 marks a GPR write.
    assign dec_long_lat = dec_inst[31];
    assign dec_rf_wen   = dec_inst[30];

    cpu7_ifu_dec_ctl #(.PC_W(32), .STALL_CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .fdp_valid(fdp_valid), .fdp_pc(fdp_pc), .fdp_inst(fdp_inst), .fdp_ready(fdp_ready),
        .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_inst(dec_inst),
        .dec_rf_wen(dec_rf_wen), .dec_long_lat(dec_long_lat), .exu_ready(exu_ready),
        .dec_stall(dec_stall), .wb_valid(wb_valid), .wb_addr(wb_addr),
        .exu_flush(exu_flush), .sb_busy(sb_busy)
`ifdef CPU7_DEC_CTL_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mbuf[$];
    logic [31:0] m_sb = '0;
    int unsigned m_stall = 0;
    int          total = 0;
    int          bad = 0;

    function automatic logic [31:0] mk(logic lng, logic wen, logic [4:0] rd_i,
                                       logic [4:0] rj_i, logic [4:0] rk_i);
        return {lng, wen, 15'd0, rk_i, rj_i, rd_i};
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(logic fv, logic [31:0] pc, logic [31:0] inst, logic er,
                       logic wbv, logic [4:0] wba, logic fl);
        logic [31:0] eff;
        logic [31:0] hi;
        logic [4:0]  hrd, hrj, hrk;
        logic        haz, ev, es, er_dy, acc, iss;
        int          cnt;
        fdp_valid = fv;
        fdp_pc    = pc;
        fdp_inst  = inst;
        exu_ready = er;
        wb_valid  = wbv;
        wb_addr   = wba;
        exu_flush = fl;
        #1;
        cnt = mbuf.size();
        eff = m_sb;
        if (wbv) eff[wba] = 1'b0;
        hi  = (cnt != 0) ? mbuf[0].inst : '0;
        hrd = hi[4:0];
        hrj = hi[9:5];
        hrk = hi[14:10];
        haz = (hrj != 0 && eff[hrj]) || (hrk != 0 && eff[hrk]) || (hi[30] && hrd != 0 && eff[hrd]);
        er_dy = !rst && cnt != 2;
        ev = cnt != 0 && !haz && !fl;
        es = cnt != 0 && haz && !fl;
        chk("fdp_ready", 32'(fdp_ready), 32'(er_dy));
        chk("dec_valid", 32'(dec_valid), 32'(ev));
        chk("dec_stall", 32'(dec_stall), 32'(es));
        chk("sb_busy", sb_busy, m_sb);
`ifdef CPU7_DEC_CTL_PERF_EN
        chk("perf_stall_cnt", perf_stall_cnt, 32'(m_stall));
`endif
        if (ev) begin
            chk("dec_pc", dec_pc, mbuf[0].pc);
            chk("dec_inst", dec_inst, mbuf[0].inst);
        end
        acc = fv && er_dy && !fl;
        iss = ev && er;
        if (rst) begin
            mbuf.delete();
            m_sb = '0;
            m_stall = 0;
        end else begin
            if (wbv && wba != 0) m_sb[wba] = 1'b0;
            if (iss && hi[31] && hi[30] && hrd != 0) m_sb[hrd] = 1'b1;
            if (es) m_stall++;
            if (fl) begin
                mbuf.delete();
            end else begin
                if (iss) void'(mbuf.pop_front());
                if (acc) mbuf.push_back('{pc, inst});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(logic er);
        cyc(1'b0, '0, '0, er, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        // reset held three cycles, then released
        repeat (3) idle(1'b0);
        rst = 1'b0;
        idle(1'b0);

        // back-to-back stream with EXU always ready
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 32'h1000 + 32'(i * 4), mk(1'b0, 1'b1, 5'(i + 1), 5'd2, 5'd3), 1'b1, 1'b0, 5'd0, 1'b0);
        idle(1'b1);
        chk("drain_empty", 32'(dec_valid), 32'd0);

        // EXU blocked: A,B fill the buffer, C waits at fetch
        cyc(1'b1, 32'h1100, mk(1'b0, 1'b1, 5'd1, 5'd0, 5'd0), 1'b0, 1'b0, 5'd0, 1'b0);
        cyc(1'b1, 32'h1104, mk(1'b0, 1'b1, 5'd2, 5'd0, 5'd0), 1'b0, 1'b0, 5'd0, 1'b0);
        cyc(1'b1, 32'h1108, mk(1'b0, 1'b1, 5'd3, 5'd0, 5'd0), 1'b0, 1'b0, 5'd0, 1'b0);
        cyc(1'b1, 32'h1108, mk(1'b0, 1'b1, 5'd3, 5'd0, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
        cyc(1'b1, 32'h1108, mk(1'b0, 1'b1, 5'd3, 5'd0, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // ld r5 then add r6,r5,r7: stall until r5 writes back
        cyc(1'b1, 32'h2000, mk(1'b1, 1'b1, 5'd5, 5'd1, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
        cyc(1'b1, 32'h2004, mk(1'b0, 1'b1, 5'd6, 5'd5, 5'd7), 1'b1, 1'b0, 5'd0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        cyc(1'b0, '0, '0, 1'b1, 1'b1, 5'd5, 1'b0);
        idle(1'b1);

        // flush with buffer full and a push in flight; r5 stays pending
        cyc(1'b1, 32'h3000, mk(1'b1, 1'b1, 5'd5, 5'd0, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
        idle(1'b1);
        cyc(1'b1, 32'h3004, mk(1'b0, 1'b1, 5'd8, 5'd5, 5'd0), 1'b0, 1'b0, 5'd0, 1'b0);
        cyc(1'b1, 32'h3008, mk(1'b0, 1'b1, 5'd9, 5'd0, 5'd0), 1'b0, 1'b0, 5'd0, 1'b0);
        cyc(1'b1, 32'h300c, mk(1'b0, 1'b1, 5'd10, 5'd0, 5'd0), 1'b1, 1'b0, 5'd0, 1'b1);
        idle(1'b1);
        chk("flush_sb5", 32'(sb_busy[5]), 32'd1);
        cyc(1'b0, '0, '0, 1'b1, 1'b1, 5'd5, 1'b0);

        // long-latency write to r0 never marks the scoreboard
        cyc(1'b1, 32'h4000, mk(1'b1, 1'b1, 5'd0, 5'd0, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
        cyc(1'b1, 32'h4004, mk(1'b0, 1'b1, 5'd11, 5'd0, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
        idle(1'b1);

        // ld r9 twice: second waits (WAW), issues with the r9 writeback; set wins
        cyc(1'b1, 32'h5000, mk(1'b1, 1'b1, 5'd9, 5'd0, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
        cyc(1'b1, 32'h5004, mk(1'b1, 1'b1, 5'd9, 5'd0, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
        idle(1'b1);
        cyc(1'b0, '0, '0, 1'b1, 1'b1, 5'd9, 1'b0);
        idle(1'b1);
        chk("sb9_set_wins", 32'(sb_busy[9]), 32'd1);
        cyc(1'b0, '0, '0, 1'b1, 1'b1, 5'd9, 1'b0);
        idle(1'b1);
        chk("final_queue", 32'(mbuf.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
